part_1_top: RTL and testbench



---
 rtl/part_1_top.sv | 127 ++++++++++++
 tb/tb_part_1_top.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/part_1_top.sv
// Sequential Taylor-term generator.
// On an accepted start, captures unsigned Q0.16 operand x and emits
// T_k = x^k / k! for k = 1..NTERMS on Tbus, one term every two clocks.
// Each term is built from the previous one by a multiply by x followed by a
// multiply by the reciprocal 1/k. Both products are truncated to Q0.16.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   start - begin a run; honoured only in idle or done
//   Xbus  - operand x, unsigned Q0.16, sampled on the start edge only
//   Tbus  - current term, unsigned Q0.16, registered
//   Done  - level, high while the last term is on Tbus
module part_1_top #(
  parameter int unsigned NTERMS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] Xbus,
  output logic [15:0] Tbus,
  output logic        Done
);

  localparam logic [3:0] KLast = 4'(NTERMS);

  typedef enum logic [1:0] {
    StIdle,
    StMulX,
    StMulR,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] p_q, p_d;
  logic [3:0]  k_q, k_d;
  logic [15:0] tbus_q, tbus_d;
  logic        done_q, done_d;

  logic [15:0] recip;
  logic [15:0] mul_b;
  logic [31:0] prod;
  logic [15:0] p_next;

  // floor(65536 / k); k only takes values 2..NTERMS while in MUL_R
  always_comb begin
    recip = 16'd0;
    unique case (k_q)
      4'd2:    recip = 16'd32768;
      4'd3:    recip = 16'd21845;
      4'd4:    recip = 16'd16384;
      4'd5:    recip = 16'd13107;
      4'd6:    recip = 16'd10922;
      4'd7:    recip = 16'd9362;
      4'd8:    recip = 16'd8192;
      default: recip = 16'd0;
    endcase
  end

  // Single shared multiplier: x in MUL_X, 1/k in MUL_R
  always_comb begin
    mul_b  = (state_q == StMulR) ? recip : x_q;
    prod   = {16'd0, p_q} * {16'd0, mul_b};
    p_next = 16'(prod >> 16);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    p_d     = p_q;
    k_d     = k_q;
    tbus_d  = tbus_q;
    done_d  = done_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          x_d     = Xbus;
          p_d     = Xbus;
          tbus_d  = Xbus;
          k_d     = 4'd2;
          done_d  = 1'b0;
          state_d = StMulX;
        end
      end
      StMulX: begin
        p_d     = p_next;
        state_d = StMulR;
      end
      StMulR: begin
        p_d    = p_next;
        tbus_d = p_next;
        if (k_q == KLast) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          k_d     = k_q + 4'd1;
          state_d = StMulX;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= 16'd0;
      p_q     <= 16'd0;
      k_q     <= 4'd0;
      tbus_q  <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      p_q     <= p_d;
      k_q     <= k_d;
      tbus_q  <= tbus_d;
      done_q  <= done_d;
    end
  end

  assign Tbus = tbus_q;
  assign Done = done_q;

endmodule

// File: tb/tb_part_1_top.sv
module tb_part_1_top;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] Xbus;
  logic [15:0] Tbus;
  logic        Done;

  int passed = 0;
  int total  = 0;
  logic [15:0] tvals [1:8];

  part_1_top #(.NTERMS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .Xbus (Xbus),
    .Tbus (Tbus),
    .Done (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Bit-exact truncating recurrence: T_k = floor(floor(T_{k-1}*x/2^16) * floor(2^16/k) / 2^16)
  function automatic logic [15:0] model_term(input logic [15:0] x, input int k);
    logic [31:0] p;
    p = {16'd0, x};
    for (int j = 2; j <= k; j++) begin
      p = (p * {16'd0, x}) >> 16;
      p = (p * (32'd65536 / j)) >> 16;
    end
    return p[15:0];
  endfunction

  // mode 0: clean pulse; 1: disturb Xbus/start mid-run; 2: start held high
  task automatic run(input logic [15:0] x, input int mode, input string name);
    int k;
    Xbus  = x;
    start = 1'b1;
    tick();  // edge 0
    for (int e = 0; e <= 14; e++) begin
      k = e / 2 + 1;
      check($sformatf("%s_T%0d_e%0d", name, k, e), {16'd0, Tbus}, {16'd0, model_term(x, k)});
      check($sformatf("%s_done_e%0d", name, e), {31'd0, Done}, {31'd0, (e == 14)});
      if (e[0]) tvals[k] = Tbus;
      if (e == 14) tvals[8] = Tbus;
      if (mode == 1 && e < 14) begin
        Xbus  = 16'($urandom);
        start = (e % 3 == 0);
      end else if (mode != 2) begin
        start = 1'b0;
      end
      if (e < 14) tick();
    end
    if (mode == 2) begin
      tick();  // edge 15: re-accepted from DONE
      check({name, "_rearm_done"}, {31'd0, Done}, 32'd0);
      check({name, "_rearm_T1"}, {16'd0, Tbus}, {16'd0, x});
      start = 1'b0;
    end else begin
      Xbus = ~x;
      for (int h = 0; h < 3; h++) begin
        tick();
        check({name, "_hold_done"}, {31'd0, Done}, 32'd1);
        check({name, "_hold_T8"}, {16'd0, Tbus}, {16'd0, model_term(x, 8)});
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    Xbus  = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_tbus", {16'd0, Tbus}, 32'h0);
      check("rst_done", {31'd0, Done}, 32'h0);
    end

    // x = 0.5, hand-computed terms
    run(16'h8000, 0, "half");
    check("half_T1", {16'd0, tvals[1]}, 32'h8000);
    check("half_T2", {16'd0, tvals[2]}, 32'h2000);
    check("half_T3", {16'd0, tvals[3]}, 32'h0555);
    check("half_T4", {16'd0, tvals[4]}, 32'h00AA);
    check("half_T5", {16'd0, tvals[5]}, 32'h0010);
    check("half_T6", {16'd0, tvals[6]}, 32'h0001);
    check("half_T8", {16'd0, tvals[8]}, 32'h0000);

    // reset between runs, then x near 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_tbus", {16'd0, Tbus}, 32'h0);
    run(16'hFFFF, 0, "max");
    check("max_T1", {16'd0, tvals[1]}, 32'hFFFF);
    check("max_T2", {16'd0, tvals[2]}, 32'h7FFF);

    // reset at edge 5 aborts the run
    Xbus  = 16'h9ABC;
    start = 1'b1;
    tick();  // edge 0
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    check("abort_pre_T3", {16'd0, Tbus}, {16'd0, model_term(16'h9ABC, 3)});
    rst = 1'b1;
    tick();  // edge 5
    rst = 1'b0;
    check("abort_tbus", {16'd0, Tbus}, 32'h0);
    check("abort_done", {31'd0, Done}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("abort_idle_tbus", {16'd0, Tbus}, 32'h0);
      check("abort_idle_done", {31'd0, Done}, 32'h0);
    end

    // reset and start together: reset wins
    rst   = 1'b1;
    start = 1'b1;
    Xbus  = 16'h4444;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_prio_tbus", {16'd0, Tbus}, 32'h0);
    tick();
    check("rst_prio_idle", {16'd0, Tbus}, 32'h0);

    // disturbed run must match undisturbed model
    run(16'h8000, 1, "dist");
    // restart from DONE with new operand
    run(16'h1234, 0, "restart");

    // zero operand
    run(16'h0000, 0, "zero");

    // start held continuously
    run(16'hC000, 2, "held");
    rst = 1'b1;
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
